// File: rtl/demux_1x2_stream.sv
`default_nettype none
// ============================================================================
// Module   : demux_1x2_stream
// Brief    : Packet-aware 1-to-2 valid/ready stream demultiplexer with a
//            one-entry register stage per output and per-output packet counts.
// Revision : 1.0 - initial release
// ============================================================================
module demux_1x2_stream #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    input  logic              s_sel,

    output logic              m0_valid,
    input  logic              m0_ready,
    output logic [DATA_W-1:0] m0_data,
    output logic              m0_last,

    output logic              m1_valid,
    input  logic              m1_ready,
    output logic [DATA_W-1:0] m1_data,
    output logic              m1_last,

    output logic              busy,
    output logic [CNT_W-1:0]  pkt_cnt0,
    output logic [CNT_W-1:0]  pkt_cnt1
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PKT0 = 2'd1,
        ST_PKT1 = 2'd2
    } state_t;

    state_t              state_q,    state_d;
    logic                m0_valid_q, m0_valid_d;
    logic [DATA_W-1:0]   m0_data_q,  m0_data_d;
    logic                m0_last_q,  m0_last_d;
    logic                m1_valid_q, m1_valid_d;
    logic [DATA_W-1:0]   m1_data_q,  m1_data_d;
    logic                m1_last_q,  m1_last_d;
    logic [CNT_W-1:0]    pkt_cnt0_q, pkt_cnt0_d;
    logic [CNT_W-1:0]    pkt_cnt1_q, pkt_cnt1_d;

    logic route;
    logic accept;
    logic load0;
    logic load1;

    always_comb begin
        route   = 1'b0;
        s_ready = 1'b0;
        accept  = 1'b0;
        load0   = 1'b0;
        load1   = 1'b0;

        // The route comes from s_sel only on a packet's first beat.
        route   = (state_q == ST_IDLE) ? s_sel : (state_q == ST_PKT1);
        // Only the selected output's register gates the input.
        s_ready = route ? (~m1_valid_q | m1_ready) : (~m0_valid_q | m0_ready);
        accept  = s_valid & s_ready;
        load0   = accept & ~route;
        load1   = accept &  route;
    end

    always_comb begin
        state_d    = state_q;
        m0_valid_d = load0 | (m0_valid_q & ~m0_ready);
        m0_data_d  = load0 ? s_data : m0_data_q;
        m0_last_d  = load0 ? s_last : m0_last_q;
        m1_valid_d = load1 | (m1_valid_q & ~m1_ready);
        m1_data_d  = load1 ? s_data : m1_data_q;
        m1_last_d  = load1 ? s_last : m1_last_q;
        pkt_cnt0_d = pkt_cnt0_q;
        pkt_cnt1_d = pkt_cnt1_q;

        if (accept) begin
            if (s_last) begin
                state_d = ST_IDLE;
                if (route) begin
                    pkt_cnt1_d = pkt_cnt1_q + CNT_W'(1);
                end else begin
                    pkt_cnt0_d = pkt_cnt0_q + CNT_W'(1);
                end
            end else if (state_q == ST_IDLE) begin
                state_d = route ? ST_PKT1 : ST_PKT0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            m0_valid_q <= 1'b0;
            m0_data_q  <= '0;
            m0_last_q  <= 1'b0;
            m1_valid_q <= 1'b0;
            m1_data_q  <= '0;
            m1_last_q  <= 1'b0;
            pkt_cnt0_q <= '0;
            pkt_cnt1_q <= '0;
        end else begin
            state_q    <= state_d;
            m0_valid_q <= m0_valid_d;
            m0_data_q  <= m0_data_d;
            m0_last_q  <= m0_last_d;
            m1_valid_q <= m1_valid_d;
            m1_data_q  <= m1_data_d;
            m1_last_q  <= m1_last_d;
            pkt_cnt0_q <= pkt_cnt0_d;
            pkt_cnt1_q <= pkt_cnt1_d;
        end
    end

    assign m0_valid = m0_valid_q;
    assign m0_data  = m0_data_q;
    assign m0_last  = m0_last_q;
    assign m1_valid = m1_valid_q;
    assign m1_data  = m1_data_q;
    assign m1_last  = m1_last_q;
    assign busy     = (state_q != ST_IDLE);
    assign pkt_cnt0 = pkt_cnt0_q;
    assign pkt_cnt1 = pkt_cnt1_q;

endmodule
`default_nettype wire

// File: tb/tb_demux_1x2_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_demux_1x2_stream
// Brief    : Self-checking bench: packet-level scoreboard plus scenario tasks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_demux_1x2_stream;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              s_valid, s_ready, s_last, s_sel;
    logic [DATA_W-1:0] s_data;
    logic              m0_valid, m0_ready, m0_last;
    logic              m1_valid, m1_ready, m1_last;
    logic [DATA_W-1:0] m0_data, m1_data;
    logic              busy;
    logic [CNT_W-1:0]  pkt_cnt0, pkt_cnt1;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    bit rand_ready = 1'b0;

    // Reference model: expected contents of each output register, packet state.
    logic [DATA_W:0]  q0[$];
    logic [DATA_W:0]  q1[$];
    bit               in_pkt = 1'b0;
    bit               pkt_route = 1'b0;
    logic [CNT_W-1:0] mdl_cnt0 = '0;
    logic [CNT_W-1:0] mdl_cnt1 = '0;

    demux_1x2_stream #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_last(s_last), .s_sel(s_sel),
        .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_data(m0_data), .m0_last(m0_last),
        .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_data(m1_data), .m1_last(m1_last),
        .busy(busy), .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            m0_ready = 1'($urandom % 2);
            m1_ready = 1'($urandom % 2);
        end
    end

    // Scoreboard: values seen at negedge are what the next rising edge will act on.
    always @(negedge clk) begin
        if (!rst_n) begin
            q0.delete();
            q1.delete();
            in_pkt   = 1'b0;
            mdl_cnt0 = '0;
            mdl_cnt1 = '0;
        end else begin
            bit rt;
            bit exp_rdy;
            tests++;
            if (m0_valid !== (q0.size() != 0)) begin
                fails++; $display("FAIL sb_m0_valid got %b exp %b", m0_valid, q0.size() != 0);
            end
            if (m0_valid === 1'b1 && q0.size() != 0) begin
                tests++;
                if ({m0_data, m0_last} !== q0[0]) begin
                    fails++; $display("FAIL sb_m0_beat got %h exp %h", {m0_data, m0_last}, q0[0]);
                end
            end
            tests++;
            if (m1_valid !== (q1.size() != 0)) begin
                fails++; $display("FAIL sb_m1_valid got %b exp %b", m1_valid, q1.size() != 0);
            end
            if (m1_valid === 1'b1 && q1.size() != 0) begin
                tests++;
                if ({m1_data, m1_last} !== q1[0]) begin
                    fails++; $display("FAIL sb_m1_beat got %h exp %h", {m1_data, m1_last}, q1[0]);
                end
            end
            tests++;
            if (pkt_cnt0 !== mdl_cnt0 || pkt_cnt1 !== mdl_cnt1) begin
                fails++; $display("FAIL sb_counts got %0d/%0d exp %0d/%0d",
                                  pkt_cnt0, pkt_cnt1, mdl_cnt0, mdl_cnt1);
            end
            tests++;
            if (busy !== in_pkt) begin
                fails++; $display("FAIL sb_busy got %b exp %b", busy, in_pkt);
            end
            rt      = in_pkt ? pkt_route : s_sel;
            exp_rdy = rt ? (q1.size() == 0 || m1_ready) : (q0.size() == 0 || m0_ready);
            tests++;
            if (s_ready !== exp_rdy) begin
                fails++; $display("FAIL sb_s_ready got %b exp %b", s_ready, exp_rdy);
            end
            if (m0_valid && m0_ready && q0.size() != 0) void'(q0.pop_front());
            if (m1_valid && m1_ready && q1.size() != 0) void'(q1.pop_front());
            if (s_valid && s_ready) begin
                if (rt) q1.push_back({s_data, s_last});
                else    q0.push_back({s_data, s_last});
                if (s_last) begin
                    in_pkt = 1'b0;
                    if (rt) mdl_cnt1 = mdl_cnt1 + 1'b1;
                    else    mdl_cnt0 = mdl_cnt0 + 1'b1;
                end else if (!in_pkt) begin
                    in_pkt    = 1'b1;
                    pkt_route = rt;
                end
            end
        end
    end

    // Presents one beat and returns at posedge+1 just after it is accepted.
    task automatic send_beat(input logic [DATA_W-1:0] d, input logic l, input logic sel);
        s_valid = 1'b1; s_data = d; s_last = l; s_sel = sel;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (s_ready === 1'b1) begin
                @(posedge clk); #1;
                return;
            end
        end
        tests++; fails++;
        $display("FAIL send_timeout got s_ready=%b exp 1 data %h", s_ready, d);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        s_valid = 1'b0;
        @(posedge clk); #1; rst_n = 1'b0;
        @(posedge clk); @(posedge clk); #1; rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        tests++;
        if (s_ready !== 1'b1 || m0_valid !== 1'b0 || m1_valid !== 1'b0 || busy !== 1'b0 ||
            pkt_cnt0 !== 0 || pkt_cnt1 !== 0 || m0_data !== 0 || m1_last !== 0) begin
            fails++; $display("FAIL reset_values got rdy=%b v=%b%b busy=%b cnt=%0d/%0d exp 1 00 0 0/0",
                              s_ready, m0_valid, m1_valid, busy, pkt_cnt0, pkt_cnt1);
        end
        @(posedge clk); @(posedge clk); #1; rst_n = 1'b1;
        m0_ready = 1'b0;
        send_beat(8'hAA, 1'b0, 1'b0);
        s_valid = 1'b0;
        tests++;
        if (m0_valid !== 1'b1 || m0_data !== 8'hAA || busy !== 1'b1) begin
            fails++; $display("FAIL reset_preload got v=%b d=%h busy=%b exp 1 aa 1", m0_valid, m0_data, busy);
        end
        @(posedge clk); #3; rst_n = 1'b0; #1;
        tests++;
        if (m0_valid !== 1'b0 || m0_data !== 8'h00 || s_ready !== 1'b1 || busy !== 1'b0 ||
            pkt_cnt0 !== 0) begin
            fails++; $display("FAIL reset_async got v=%b d=%h rdy=%b busy=%b cnt0=%0d exp 0 00 1 0 0",
                              m0_valid, m0_data, s_ready, busy, pkt_cnt0);
        end
        @(posedge clk); @(posedge clk); #1; rst_n = 1'b1; m0_ready = 1'b1;
    endtask

    task automatic test_stream_m0();
        m0_ready = 1'b1; m1_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send_beat(8'(8'h11 + i), 1'(i == 3), 1'b0);
            tests++;
            if (m0_valid !== 1'b1 || m0_data !== 8'(8'h11 + i) || m0_last !== 1'(i == 3) || m1_valid !== 1'b0) begin
                fails++; $display("FAIL stream_m0_beat%0d got v=%b d=%h l=%b m1v=%b exp 1 %h %b 0",
                                  i, m0_valid, m0_data, m0_last, m1_valid, 8'(8'h11 + i), i == 3);
            end
        end
        idle(2);
        tests++;
        if (pkt_cnt0 !== 2'd1 || pkt_cnt1 !== 2'd0) begin
            fails++; $display("FAIL stream_m0_cnt got %0d/%0d exp 1/0", pkt_cnt0, pkt_cnt1);
        end
    endtask

    task automatic test_route_hold();
        logic [2:0] busy_seen;
        for (int i = 0; i < 3; i++) begin
            send_beat(8'(8'h61 + i), 1'(i == 2), 1'(i == 0));
            busy_seen[i] = busy;
            tests++;
            if (m1_valid !== 1'b1 || m1_data !== 8'(8'h61 + i) || m0_valid !== 1'b0) begin
                fails++; $display("FAIL route_hold_beat%0d got m1v=%b d=%h m0v=%b exp 1 %h 0",
                                  i, m1_valid, m1_data, m0_valid, 8'(8'h61 + i));
            end
        end
        idle(2);
        tests++;
        if (busy_seen !== 3'b011 || pkt_cnt1 !== 2'd1) begin
            fails++; $display("FAIL route_hold_busy got busy=%b cnt1=%0d exp 011 1", busy_seen, pkt_cnt1);
        end
    endtask

    task automatic test_backpressure();
        m1_ready = 1'b0;
        send_beat(8'h55, 1'b1, 1'b1);
        send_beat(8'h21, 1'b0, 1'b0);
        m0_ready = 1'b0; m1_ready = 1'b1;
        s_valid = 1'b1; s_data = 8'h22; s_last = 1'b0; s_sel = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests++;
            if (s_ready !== 1'b0 || m0_valid !== 1'b1 || m0_data !== 8'h21) begin
                fails++; $display("FAIL bp_stall%0d got rdy=%b v=%b d=%h exp 0 1 21",
                                  i, s_ready, m0_valid, m0_data);
            end
        end
        tests++;
        if (m1_valid !== 1'b0) begin
            fails++; $display("FAIL bp_m1_drain got %b exp 0", m1_valid);
        end
        @(posedge clk); #1; m0_ready = 1'b1;
        send_beat(8'h22, 1'b0, 1'b1);
        send_beat(8'h23, 1'b0, 1'b1);
        send_beat(8'h24, 1'b1, 1'b1);
        idle(3);
        tests++;
        if (pkt_cnt0 !== 2'd2 || pkt_cnt1 !== 2'd2 || m0_valid !== 1'b0 || q0.size() != 0) begin
            fails++; $display("FAIL bp_final got cnt=%0d/%0d v=%b pend=%0d exp 2/2 0 0",
                              pkt_cnt0, pkt_cnt1, m0_valid, q0.size());
        end
    endtask

    task automatic test_back_to_back();
        int c0;
        do_reset();
        m0_ready = 1'b1; m1_ready = 1'b1;
        c0 = cyc;
        for (int i = 0; i < 4; i++) begin
            send_beat(8'(8'hA0 + i), 1'b1, 1'(i % 2));
            tests++;
            if (busy !== 1'b0 || (i % 2 == 0 ? m0_data : m1_data) !== 8'(8'hA0 + i)) begin
                fails++; $display("FAIL b2b_beat%0d got busy=%b d=%h exp 0 %h",
                                  i, busy, (i % 2 == 0 ? m0_data : m1_data), 8'(8'hA0 + i));
            end
        end
        tests++;
        if (cyc - c0 != 4) begin
            fails++; $display("FAIL b2b_cycles got %0d exp 4", cyc - c0);
        end
        idle(2);
        tests++;
        if (pkt_cnt0 !== 2'd2 || pkt_cnt1 !== 2'd2) begin
            fails++; $display("FAIL b2b_cnt got %0d/%0d exp 2/2", pkt_cnt0, pkt_cnt1);
        end
    endtask

    task automatic test_wrap_and_reset();
        do_reset();
        for (int p = 0; p < 5; p++) begin
            send_beat(8'(8'hC0 + p), 1'(p % 2 == 0), 1'b1);
            if (p % 2 == 1) send_beat(8'(8'hD0 + p), 1'b1, 1'b0);
        end
        idle(2);
        tests++;
        if (pkt_cnt1 !== 2'd1 || pkt_cnt0 !== 2'd0) begin
            fails++; $display("FAIL wrap_cnt got %0d/%0d exp 0/1", pkt_cnt0, pkt_cnt1);
        end
        send_beat(8'h31, 1'b0, 1'b1);
        s_data = 8'h32; s_last = 1'b0; s_valid = 1'b1;
        #2; rst_n = 1'b0; s_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1; rst_n = 1'b1;
        send_beat(8'h41, 1'b0, 1'b0);
        tests++;
        if (m0_valid !== 1'b1 || m0_data !== 8'h41 || m1_valid !== 1'b0) begin
            fails++; $display("FAIL rst_mid_first got m0v=%b d=%h m1v=%b exp 1 41 0", m0_valid, m0_data, m1_valid);
        end
        send_beat(8'h42, 1'b1, 1'b1);
        tests++;
        if (m0_data !== 8'h42 || m0_last !== 1'b1 || m1_valid !== 1'b0) begin
            fails++; $display("FAIL rst_mid_second got d=%h l=%b m1v=%b exp 42 1 0", m0_data, m0_last, m1_valid);
        end
        idle(2);
        tests++;
        if (pkt_cnt0 !== 2'd1 || pkt_cnt1 !== 2'd0) begin
            fails++; $display("FAIL rst_mid_cnt got %0d/%0d exp 1/0", pkt_cnt0, pkt_cnt1);
        end
    endtask

    task automatic test_random();
        int exp0;
        int exp1;
        int len;
        logic sel;
        do_reset();
        exp0 = 0; exp1 = 0;
        rand_ready = 1'b1;
        for (int p = 0; p < 40; p++) begin
            len = $urandom_range(1, 4);
            sel = 1'($urandom % 2);
            for (int b = 0; b < len; b++)
                send_beat(8'($urandom), 1'(b == len - 1), (b == 0) ? sel : 1'($urandom % 2));
            if (sel) exp1++; else exp0++;
            if ($urandom % 4 == 0) idle(1);
        end
        s_valid = 1'b0;
        @(posedge clk);
        rand_ready = 1'b0;
        #2; m0_ready = 1'b1; m1_ready = 1'b1;
        idle(4);
        tests++;
        if (pkt_cnt0 !== 2'(exp0) || pkt_cnt1 !== 2'(exp1) || m0_valid !== 1'b0 || m1_valid !== 1'b0) begin
            fails++; $display("FAIL random_final got cnt=%0d/%0d v=%b%b exp %0d/%0d 00",
                              pkt_cnt0, pkt_cnt1, m0_valid, m1_valid, 2'(exp0), 2'(exp1));
        end
    endtask

    initial begin
        rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; s_sel = 1'b0;
        m0_ready = 1'b1; m1_ready = 1'b1;
        test_reset();
        test_stream_m0();
        test_route_hold();
        test_backpressure();
        test_back_to_back();
        test_wrap_and_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
